instruction_encoder: RTL
========================

Name: instruction_encoder

Overview:
- Encoder end of the 32-bit `komut` instruction format that the decoder consumes.
- Takes instruction fields (type, rd, rs1, rs2, aluop, imm), range-checks them and packs them into one 32-bit word.
- Buffers the word in a small FIFO and streams it out with a valid/ready handshake.
- Sits between the test/program source and the decoder's `komut` input.

Parameters:
DEPTH, 4, FIFO depth in words; power of two, 2..16.
CNT_W, $clog2(DEPTH)+1, width of the fill-level output.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
tip  input  2  instruction type: 0=R, 1=I, 2=U, 3=B.
rd  input  5  destination register.
rs1  input  5  source register 1.
rs2  input  5  source register 2.
aluop  input  4  ALU operation.
imm  input  32  immediate, two's complement.
in_valid  input  1  input fields valid.
in_ready  output  1  encoder can accept a word.
komut  output  32  encoded instruction at FIFO head.
out_valid  output  1  komut valid.
out_ready  input  1  consumer takes komut.
hata  output  1  one-cycle pulse: last accepted fields were illegal.
doluluk  output  CNT_W  FIFO fill level.

Behaviour:
- Accept occurs when in_valid && in_ready. in_ready = (doluluk != DEPTH), registered-state based.
- A pop at full does not open the input in the same cycle.
- Encoding (opcode in [6:0]):
  - R (opcode 0000001): [11:7]=rd, [14:12]=aluop[2:0], [19:15]=rs1, [24:20]=rs2, [30]=aluop[3], [31], [29:25]=0.
  - I (opcode 0000011): [31:20]=imm[11:0], [19:15]=rs1, [14:12]=aluop[2:0], [11:7]=rd.
  - U (opcode 0000111): [31:12]=imm[31:12], [11:7]=rd.
  - B (opcode 0001111): [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=aluop[2:0], [11:7]=imm[4:0].
- Legality checks; an illegal accepted word is dropped (not pushed):
  - I/B: imm[31:11] must be all equal (signed 12-bit range) and aluop[3]=0.
  - U: imm[11:0] must be 0.
  - R: always legal.
- hata: registered; goes 1 in the cycle after an illegal accept and lasts exactly one cycle. Back-to-back illegal accepts keep it high.
- FIFO is first-word-fall-through.
  - A legal accept into an empty FIFO gives out_valid=1 on the next clock edge (latency 1).
  - komut = head word when out_valid=1, else 32'h0.
- Pop occurs on out_valid && out_ready.
- Simultaneous push and pop (not full): doluluk unchanged and order preserved.
- Pop with push at empty: the pushed word appears next cycle.
- Read/write pointers wrap modulo DEPTH. doluluk is exact, 0..DEPTH.
- Reset (async assert, any time, including mid-transfer):
  - Pointers and doluluk go to 0; out_valid=0, komut=0, hata=0; in_ready=1 once rst_n=1.
  - Buffered words are discarded.
  - Deassertion is synchronised in the design's reset domain.

Optional Feature:
- Macro: INSTR_ENC_ERR_CNT_EN.
- Defined: adds output hata_sayac (8 bits).
  - Counts illegal accepts; saturates at 255; reset to 0.
  - Cleared by rst_n only.
- Not defined: port absent; no counter logic; all other behaviour identical.

Test Plan:
- R encode: tip=0, rd=3, rs1=5, rs2=7, aluop=4'b1010, single accept, out_ready=1 -> next cycle out_valid=1, komut=32'h4072A181, hata=0.
- I encode: tip=1, imm=32'hFFFFFFF8, rs1=4, aluop=0, rd=31 -> komut=32'hFF820F83.
- U encode: tip=2, imm=32'h12345000, rd=5 -> komut=32'h12345287.
- Illegal words:
  - tip=1, imm=32'h00000800 -> hata=1 for exactly one cycle, doluluk stays 0, out_valid stays 0.
  - tip=2, imm=32'h12345001 -> same response.
  - With INSTR_ENC_ERR_CNT_EN defined, hata_sayac=2 after both.
- Backpressure (DEPTH=4): out_ready=0, offer 5 legal R words -> in_ready=0 after 4th accept, doluluk=4, 5th held. Then out_ready=1 -> words pop in order, 5th accepted, doluluk returns to 0, no loss or duplicate.
- Reset mid-operation: 3 words buffered, pulse rst_n low between clock edges -> out_valid=0, komut=0, doluluk=0 immediately. After release, a new R word encodes correctly with latency 1.

Source files
------------

// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Packs instruction fields (tip, rd, rs1, rs2, aluop, imm) into the 32-bit
//   komut word consumed by the decoder, range-checks them, buffers legal
//   words in a first-word-fall-through FIFO and streams them out with a
//   valid/ready handshake. Illegal words are dropped and flagged on hata.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   tip, rd, rs1, rs2,  instruction fields (tip: 0=R 1=I 2=U 3=B)
//   aluop, imm
//   in_valid/in_ready   input handshake
//   komut/out_valid/    FIFO head word (0 when empty) and output handshake
//   out_ready
//   hata                one-cycle pulse after an illegal accept
//   doluluk             FIFO fill level, 0..DEPTH
//   hata_sayac          saturating illegal-accept counter
//                       (only when INSTR_ENC_ERR_CNT_EN is defined)
//
// Optional feature macro: INSTR_ENC_ERR_CNT_EN

module instruction_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       tip,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [3:0]       aluop,
  input  logic [31:0]      imm,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      komut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             hata,
  output logic [CNT_W-1:0] doluluk
`ifdef INSTR_ENC_ERR_CNT_EN
  ,
  output logic [7:0]       hata_sayac
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OPC_R = 7'b0000001;
  localparam logic [6:0] OPC_I = 7'b0000011;
  localparam logic [6:0] OPC_U = 7'b0000111;
  localparam logic [6:0] OPC_B = 7'b0001111;

  // Reset: asserts asynchronously, releases synchronously to clk.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Field packing and legality check.
  logic [31:0] enc_word;
  logic        legal;
  logic        imm12_ok;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    // Fits signed 12 bits when imm[31:11] is all ones or all zeros.
    imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    case (tip)
      2'd0: begin
        enc_word = {1'b0, aluop[3], 5'b00000, rs2, rs1, aluop[2:0], rd, OPC_R};
        legal    = 1'b1;
      end
      2'd1: begin
        enc_word = {imm[11:0], rs1, aluop[2:0], rd, OPC_I};
        legal    = imm12_ok & ~aluop[3];
      end
      2'd2: begin
        enc_word = {imm[31:12], rd, OPC_U};
        legal    = (imm[11:0] == 12'h000);
      end
      default: begin
        enc_word = {imm[11:5], rs2, rs1, aluop[2:0], imm[4:0], OPC_B};
        legal    = imm12_ok & ~aluop[3];
      end
    endcase
  end

  // FIFO control.
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CNT_W-1:0] cnt_after_pop;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      head_nxt;
  logic             accept;
  logic             push;
  logic             pop;

  always_comb begin
    accept        = in_valid & in_ready;
    push          = accept & legal;
    pop           = out_valid & out_ready;
    rd_ptr_nxt    = rd_ptr_q + AW'(pop);
    cnt_after_pop = doluluk - CNT_W'(pop);
    cnt_nxt       = cnt_after_pop + CNT_W'(push);
    // Next head: the word being pushed if the FIFO drains to empty,
    // otherwise the stored word at the advanced read pointer.
    if (cnt_after_pop == '0) begin
      head_nxt = push ? enc_word : 32'h0;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= enc_word;
    end
  end

  // Pointers, fill level and registered outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      doluluk   <= '0;
      out_valid <= 1'b0;
      komut     <= 32'h0;
      in_ready  <= 1'b0;
      hata      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + AW'(push);
      rd_ptr_q  <= rd_ptr_nxt;
      doluluk   <= cnt_nxt;
      out_valid <= (cnt_nxt != '0);
      komut     <= head_nxt;
      in_ready  <= (cnt_nxt != CNT_W'(DEPTH));
      hata      <= accept & ~legal;
    end
  end

`ifdef INSTR_ENC_ERR_CNT_EN
  // Saturating count of illegal accepts.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hata_sayac <= 8'h00;
    end else if (accept && !legal && (hata_sayac != 8'hFF)) begin
      hata_sayac <= hata_sayac + 8'h01;
    end
  end
`endif

endmodule
